// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: initiator-side sequencer for a single-port RAM with a
// one-cycle registered read. It takes one command at a time on a
// valid/ready request port, drives the RAM, and returns one response per
// command on a valid/ready response port.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. A source holds valid and its payload stable
// until that edge. This block holds rsp_valid/rsp_rdata/rsp_err stable until
// rsp_ready is seen. Backpressure may last indefinitely.
//
// Optional feature: define ADDR_CHECK_EN to reject commands whose address is
// >= depth. A rejected command is answered with rsp_err=1 and never reaches
// the RAM. Without the macro rsp_err is constant 0 and every address goes to
// the RAM unchanged.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP.
module ram_access_ctrl #(
  parameter int addr_width = 6,
  parameter int data_width = 8,
  parameter int depth      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [addr_width-1:0] req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_data,
  input  logic [data_width-1:0] ram_q,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state, state_d;
  logic                  req_ready_d;
  logic                  rsp_valid_d;
  logic                  rsp_err_d;
  logic [data_width-1:0] rsp_rdata_d;
  logic                  ram_we_d;
  logic [addr_width-1:0] ram_addr_d;
  logic [data_width-1:0] ram_data_d;
  logic                  addr_oor;

`ifdef ADDR_CHECK_EN
  // One extra bit so that depth == 2**addr_width is representable.
  localparam logic [addr_width:0] depth_lim = (addr_width+1)'(depth);
  assign addr_oor = ({1'b0, req_addr} >= depth_lim);
`else
  assign addr_oor = 1'b0;
`endif

  assign dbg_state = state;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state;
    req_ready_d = req_ready;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    ram_we_d    = ram_we;
    ram_addr_d  = ram_addr;
    ram_data_d  = ram_data;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          if (addr_oor) begin
            // Rejected: answer immediately, RAM is never touched.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else begin
            ram_addr_d = req_addr;
            ram_data_d = req_wdata;
            ram_we_d   = req_we;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        // RAM samples its inputs at the edge leaving this state.
        ram_we_d = 1'b0;
        if (ram_we) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // ram_q now carries the word addressed during ISSUE.
        rsp_rdata_d = ram_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else begin
      state     <= state_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_data  <= ram_data_d;
    end
  end

endmodule
